// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU datapath among N_REQ requesters.
// A grant registers the winner's opcode and operands onto the ALU inputs. The
// ALU result is captured one cycle later and held on a one-hot response
// handshake until the owning requester accepts it. One operation is in
// flight at a time.
module alu_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32,
    parameter int OP_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*OP_W-1:0]  req_op,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [OP_W-1:0]        alu_op,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    input  logic [WIDTH-1:0]       alu_result,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]       rsp_data
);
    localparam int PTR_W = $clog2(N_REQ);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [OP_W-1:0]  alu_op_q, alu_op_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;

    // Per-requester views of the flattened request buses
    logic [OP_W-1:0]  op_arr [N_REQ];
    logic [WIDTH-1:0] a_arr  [N_REQ];
    logic [WIDTH-1:0] b_arr  [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign op_arr[gi] = req_op[gi*OP_W +: OP_W];
            assign a_arr[gi]  = req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi]  = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    logic             found;
    logic [PTR_W-1:0] winner;
    logic [PTR_W:0]   scan_sum;
    logic [N_REQ-1:0] grant;

    // Round-robin scan: first valid requester at or after rr_ptr, wrapping
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_sum = '0;
        grant    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (scan_sum >= (PTR_W+1)'(N_REQ)) begin
                scan_sum = scan_sum - (PTR_W+1)'(N_REQ);
            end
            if (!found && req_valid[scan_sum[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = scan_sum[PTR_W-1:0];
            end
        end
        if (found) begin
            grant[winner] = 1'b1;
        end
    end

    // Grant only while idle and out of reset; the one-hot grant is the accept
    assign req_ready = (rst_n && state_q == IDLE) ? grant : '0;

    // Next-state and datapath register updates for the IDLE/EXEC/RESP sequence
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    alu_op_d = op_arr[winner];
                    alu_a_d  = a_arr[winner];
                    alu_b_d  = b_arr[winner];
                    owner_d  = winner;
                    rr_ptr_d = (winner == PTR_W'(N_REQ-1)) ? '0 : winner + PTR_W'(1);
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                // ALU inputs have been stable for a full cycle; take the result
                rsp_data_d           = alu_result;
                rsp_valid_d          = '0;
                rsp_valid_d[owner_q] = 1'b1;
                state_d              = RESP;
            end
            RESP: begin
                // Only the owner's ready bit can complete the response
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; asynchronous reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_valid = rsp_valid_q;

endmodule
